accum_scheduler: RTL and testbench

ACCUM_SCHEDULER -- requirements
Module: accum_scheduler

---
 rtl/accum_scheduler.sv | 148 ++++++++++++++
 tb/tb_accum_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/accum_scheduler.sv
// ============================================================================
// Module   : accum_scheduler
// Brief    : Round-robin 4-requester arbiter feeding a batch accumulator.
//            Define ACCUM_SAT_EN to clamp the sum and raise a sticky sat flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_scheduler #(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 16,
  parameter int TARGET = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] data,
  input  logic                clear,
  output logic [3:0]          grant,
  output logic [SUM_W-1:0]    sum,
  output logic [15:0]         count,
  output logic                done,
  output logic                sat
);

  localparam logic [15:0] c_TARGET = 16'(TARGET);

  typedef enum logic [1:0] {
    ST_ARB  = 2'b00,
    ST_ACC  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t              r_state;
  logic [3:0]          r_grant;
  logic [SUM_W-1:0]    r_sum;
  logic [15:0]         r_count;
  logic                r_done;
  logic [1:0]          r_ptr;
  logic [1:0]          r_gidx;
  logic [DATA_W-1:0]   r_operand;

  logic [1:0]          w_win;
  logic [1:0]          w_cand;
  logic                w_found;
  logic [DATA_W-1:0]   w_operand;
  logic [SUM_W:0]      w_add;
  logic [15:0]         w_count_nxt;

  // Search starts one past ptr; the fourth candidate is ptr itself.
  always_comb begin
    w_win   = r_ptr;
    w_cand  = r_ptr;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_found && req[w_cand]) begin
        w_win   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_operand   = data[int'(w_win)*DATA_W +: DATA_W];
  assign w_add       = {1'b0, r_sum} + {{(SUM_W+1-DATA_W){1'b0}}, r_operand};
  assign w_count_nxt = r_count + 16'd1;

`ifdef ACCUM_SAT_EN
  logic r_sat;
  assign sat = r_sat;
`else
  assign sat = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_ARB;
      r_grant   <= 4'b0000;
      r_sum     <= '0;
      r_count   <= 16'd0;
      r_done    <= 1'b0;
      r_ptr     <= 2'd3;
      r_gidx    <= 2'd0;
      r_operand <= '0;
`ifdef ACCUM_SAT_EN
      r_sat     <= 1'b0;
`endif
    end else if (clear) begin
      r_state   <= ST_ARB;
      r_grant   <= 4'b0000;
      r_sum     <= '0;
      r_count   <= 16'd0;
      r_done    <= 1'b0;
`ifdef ACCUM_SAT_EN
      r_sat     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_found) begin
            r_grant   <= 4'b0001 << w_win;
            r_gidx    <= w_win;
            r_operand <= w_operand;
            r_state   <= ST_ACC;
          end
        end
        ST_ACC: begin
          r_grant <= 4'b0000;
          r_ptr   <= r_gidx;
          r_count <= w_count_nxt;
`ifdef ACCUM_SAT_EN
          if (w_add[SUM_W]) begin
            r_sum <= '1;
            r_sat <= 1'b1;
          end else begin
            r_sum <= w_add[SUM_W-1:0];
          end
`else
          r_sum <= w_add[SUM_W-1:0];
`endif
          if (w_count_nxt == c_TARGET) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_ARB;
          end
        end
        ST_DONE: begin
          r_grant <= 4'b0000;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_ARB;
          r_grant <= 4'b0000;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign sum   = r_sum;
  assign count = r_count;
  assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_accum_scheduler.sv
// ============================================================================
// Module   : tb_accum_scheduler
// Brief    : Directed and randomized checks of accum_scheduler against a
//            transaction-level model (honours ACCUM_SAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accum_scheduler;

  localparam int DW   = 8;
  localparam int SW   = 8;
  localparam int TG   = 4;
  localparam int MAXV = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [4*DW-1:0] data;
  logic          clear;
  logic [3:0]    grant;
  logic [SW-1:0] sum;
  logic [15:0]   count;
  logic          done;
  logic          sat;

  accum_scheduler #(.DATA_W(DW), .SUM_W(SW), .TARGET(TG)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .data  (data),
    .clear (clear),
    .grant (grant),
    .sum   (sum),
    .count (count),
    .done  (done),
    .sat   (sat)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: one transaction = grant cycle followed by an accumulate cycle.
  int       m_sum, m_count, m_ptr, m_widx, m_op;
  logic [3:0] m_grant;
  bit       m_pending, m_done, m_sat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sum = 0; m_count = 0; m_ptr = 3; m_widx = 0; m_op = 0;
    m_grant = 4'b0000; m_pending = 0; m_done = 0; m_sat = 0;
  endtask

  task automatic model_step();
    int s;
    int w;
    if (clear) begin
      m_sum = 0; m_count = 0; m_sat = 0; m_grant = 4'b0000;
      m_pending = 0; m_done = 0;
    end else if (m_done) begin
      m_grant = 4'b0000;
    end else if (m_pending) begin
      m_grant = 4'b0000;
      m_ptr   = m_widx;
      s = m_sum + m_op;
`ifdef ACCUM_SAT_EN
      if (s > MAXV) begin m_sum = MAXV; m_sat = 1; end else m_sum = s;
`else
      m_sum = s % (MAXV + 1);
`endif
      m_count++;
      m_pending = 0;
      m_done = (m_count == TG);
    end else if (req != 4'b0000) begin
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      m_widx    = w;
      m_op      = int'(data[w*DW +: DW]);
      m_grant   = 4'b0001 << w;
      m_pending = 1;
    end
  endtask

  task automatic compare_all();
    chk("grant", {28'd0, grant}, {28'd0, m_grant});
    chk("sum",   {24'd0, sum},   32'(m_sum));
    chk("count", {16'd0, count}, 32'(m_count));
    chk("done",  {31'd0, done},  {31'd0, m_done});
    chk("sat",   {31'd0, sat},   {31'd0, m_sat});
  endtask

  task automatic tick(input logic [3:0] r, input logic [31:0] d, input logic c);
    req = r; data = d; clear = c;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  int ngrants;

  initial begin
    reset = 1'b1; req = 4'b0000; data = '0; clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset_sum_lit", {24'd0, sum}, 32'd0);
    chk("reset_grant_lit", {28'd0, grant}, 32'd0);
    reset = 1'b0;

    // Round-robin over all four requesters, then wrap after a clear.
    tick(4'b1111, 32'h01010101, 1'b0); chk("rr_g0", {28'd0, grant}, 32'h1);
    tick(4'b1111, 32'h01010101, 1'b0); chk("rr_c1", {16'd0, count}, 32'd1);
    tick(4'b1111, 32'h01010101, 1'b0); chk("rr_g1", {28'd0, grant}, 32'h2);
    tick(4'b1111, 32'h01010101, 1'b0);
    tick(4'b1111, 32'h01010101, 1'b0); chk("rr_g2", {28'd0, grant}, 32'h4);
    tick(4'b1111, 32'h01010101, 1'b0);
    tick(4'b1111, 32'h01010101, 1'b0); chk("rr_g3", {28'd0, grant}, 32'h8);
    tick(4'b1111, 32'h01010101, 1'b0); chk("rr_done", {31'd0, done}, 32'd1);
    tick(4'b1111, 32'h01010101, 1'b0); chk("rr_hold", {28'd0, grant}, 32'h0);
    tick(4'b1111, 32'h01010101, 1'b1); chk("rr_clr", {16'd0, count}, 32'd0);
    tick(4'b1111, 32'h01010101, 1'b0); chk("rr_wrap", {28'd0, grant}, 32'h1);

    // Single requester held until the batch completes.
    tick(4'b0000, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) tick(4'b0100, 32'h00100000, 1'b0);
    chk("batch_sum", {24'd0, sum}, 32'h40);
    chk("batch_cnt", {16'd0, count}, 32'd4);
    chk("batch_done", {31'd0, done}, 32'd1);
    tick(4'b0100, 32'h00100000, 1'b0);
    tick(4'b0100, 32'h00100000, 1'b0); chk("batch_nogrant", {28'd0, grant}, 32'h0);

    // One-cycle req pulse yields exactly one transaction.
    tick(4'b0000, 32'h0, 1'b1);
    ngrants = 0;
    tick(4'b0010, 32'h00000700, 1'b0); if (grant != 0) ngrants++;
    chk("pulse_grant", {28'd0, grant}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      tick(4'b0000, 32'h0, 1'b0); if (grant != 0) ngrants++;
    end
    chk("pulse_ngrants", 32'(ngrants), 32'd1);
    chk("pulse_sum", {24'd0, sum}, 32'h07);
    chk("pulse_cnt", {16'd0, count}, 32'd1);

    // Overflow: saturate or wrap depending on build.
    tick(4'b0000, 32'h0, 1'b1);
    tick(4'b0001, 32'h000000F0, 1'b0);
    tick(4'b0000, 32'h0, 1'b0); chk("ovf_first", {24'd0, sum}, 32'hF0);
    tick(4'b0001, 32'h00000020, 1'b0);
    tick(4'b0000, 32'h0, 1'b0);
`ifdef ACCUM_SAT_EN
    chk("ovf_sum", {24'd0, sum}, 32'hFF);
    chk("ovf_sat", {31'd0, sat}, 32'd1);
`else
    chk("ovf_sum", {24'd0, sum}, 32'h10);
    chk("ovf_sat", {31'd0, sat}, 32'd0);
`endif

    // clear while an accumulation is pending discards it.
    tick(4'b0000, 32'h0, 1'b1);
    tick(4'b0001, 32'h00000005, 1'b0);
    tick(4'b0000, 32'h0, 1'b0); chk("clr_pre", {24'd0, sum}, 32'h05);
    tick(4'b0001, 32'h00000003, 1'b0);
    tick(4'b0000, 32'h0, 1'b1);
    chk("clr_sum", {24'd0, sum}, 32'd0);
    chk("clr_cnt", {16'd0, count}, 32'd0);
    tick(4'b0000, 32'h0, 1'b0); chk("clr_lost", {24'd0, sum}, 32'd0);

    // Asynchronous reset in the middle of an accumulation.
    tick(4'b0001, 32'h00000009, 1'b0);
    tick(4'b0000, 32'h0, 1'b0);
    tick(4'b0001, 32'h00000002, 1'b0);
    reset = 1'b1;
    #1;
    chk("arst_sum", {24'd0, sum}, 32'd0);
    chk("arst_cnt", {16'd0, count}, 32'd0);
    chk("arst_grant", {28'd0, grant}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    model_reset();
    @(negedge clk);
    compare_all();
    reset = 1'b0;

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 600; i++)
      tick(4'($urandom_range(0, 15)), $urandom(), ($urandom_range(0, 15) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
